// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: FSM encoding and register/word widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  // MEM-stage access FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/mem_wb_reg.sv
// ME/WB boundary register: captures the write-back payload and marks it valid.
// Latency: 1 cycle from load to wb_* outputs.
// Backpressure: none; WB always accepts, payload holds while no new load arrives.
module mem_wb_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  reg_addr_t         dest,
  input  logic              regwr,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output reg_addr_t         wb_dest,
  output logic              wb_regwr
);

  // Valid follows load every cycle; payload only moves when a new result lands
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_dest  <= '0;
      wb_regwr <= 1'b0;
    end else begin
      wb_valid <= load;
      if (load) begin
        wb_data  <= data;
        wb_dest  <= dest;
        wb_regwr <= regwr;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: word loads/stores over a req/ack dmem handshake, ME/WB payload out.
// Latency: ALU ops 1 edge; memory ops 2 edges minimum (ack on first req cycle).
// Backpressure: stall held while an access is open; optional DMEM_TIMEOUT_EN bounds the wait.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] regin1,
  input  logic [DATA_W-1:0] regin2,
  input  reg_addr_t         regin3,
  input  logic              mem2regin,
  input  logic              memwrin,
  input  logic              regwrin,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output reg_addr_t         wb_dest,
  output logic              wb_regwr,
  output logic              mem_err
);

  logic [0:0]        state;
  logic              mem_op;
  logic              start;
  logic              ack_hit;
  logic              tmo_hit;
  logic [DATA_W-1:0] lat_alu;
  reg_addr_t         lat_dest;
  logic              lat_mem2reg;
  logic              lat_regwr;
  logic              wb_load;
  logic [DATA_W-1:0] wb_data_nxt;
  reg_addr_t         wb_dest_nxt;
  logic              wb_regwr_nxt;

  assign mem_op  = mem2regin | memwrin;
  assign start   = (state == ST_IDLE) && in_valid && mem_op;
  assign ack_hit = (state == ST_WAIT) && dmem_ack;

`ifdef DMEM_TIMEOUT_EN
  logic [4:0] wait_cnt;

  // Ack in the timeout cycle takes priority, so timeout only fires without ack
  assign tmo_hit = (state == ST_WAIT) && !dmem_ack && (wait_cnt == 5'(TIMEOUT - 1));

  // Count WAIT cycles without ack; restart on every new access
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= '0;
    end else if ((state == ST_WAIT) && !dmem_ack) begin
      wait_cnt <= wait_cnt + 5'd1;
    end
  end

  // One-cycle error pulse on the edge that abandons the access
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_err <= 1'b0;
    end else begin
      mem_err <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Stall on the presentation cycle and through WAIT, releasing on the closing cycle
  assign stall = start || ((state == ST_WAIT) && !dmem_ack && !tmo_hit);

  // FSM plus dmem request signals; request fields stay frozen until completion
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_WAIT;
            dmem_req   <= 1'b1;
            dmem_we    <= memwrin;
            dmem_addr  <= {regin1[DATA_W-1:2], 2'b00};
            dmem_wdata <= regin2;
          end
        end
        default: begin
          if (ack_hit || tmo_hit) begin
            state    <= ST_IDLE;
            dmem_req <= 1'b0;
          end
        end
      endcase
    end
  end

  // Remember the write-back context of the open access while upstream is frozen
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_alu     <= '0;
      lat_dest    <= '0;
      lat_mem2reg <= 1'b0;
      lat_regwr   <= 1'b0;
    end else if (start) begin
      lat_alu     <= regin1;
      lat_dest    <= regin3;
      lat_mem2reg <= mem2regin;
      lat_regwr   <= regwrin;
    end
  end

  // Select the write-back payload: direct ALU path, completed access, or abandoned access
  always_comb begin
    wb_load      = 1'b0;
    wb_data_nxt  = regin1;
    wb_dest_nxt  = regin3;
    wb_regwr_nxt = regwrin;
    if (state == ST_IDLE) begin
      wb_load = in_valid && !mem_op;
    end else if (ack_hit) begin
      wb_load      = 1'b1;
      wb_data_nxt  = lat_mem2reg ? dmem_rdata : lat_alu;
      wb_dest_nxt  = lat_dest;
      wb_regwr_nxt = lat_regwr && !dmem_we;
    end else if (tmo_hit) begin
      wb_load      = 1'b1;
      wb_data_nxt  = lat_alu;
      wb_dest_nxt  = lat_dest;
      wb_regwr_nxt = 1'b0;
    end
  end

  mem_wb_reg #(
    .DATA_W(DATA_W)
  ) u_mem_wb_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (wb_load),
    .data     (wb_data_nxt),
    .dest     (wb_dest_nxt),
    .regwr    (wb_regwr_nxt),
    .wb_valid (wb_valid),
    .wb_data  (wb_data),
    .wb_dest  (wb_dest),
    .wb_regwr (wb_regwr)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: ALU vector table plus load/store/reset/timeout sequences.
// Latency: n/a.
// Backpressure: bench acts as upstream and memory; holds EX/ME while stall is high.
module tb_mem_access_stage;
  import mips_pkg::*;

`ifdef DMEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] regin1;
  logic [31:0] regin2;
  reg_addr_t   regin3;
  logic        mem2regin;
  logic        memwrin;
  logic        regwrin;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  reg_addr_t   wb_dest;
  logic        wb_regwr;
  logic        mem_err;

  int checks   = 0;
  int failures = 0;

  mem_access_stage #(.DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .regin1     (regin1),
    .regin2     (regin2),
    .regin3     (regin3),
    .mem2regin  (mem2regin),
    .memwrin    (memwrin),
    .regwrin    (regwrin),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_dest    (wb_dest),
    .wb_regwr   (wb_regwr),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] r3, input logic m2r, input logic mw, input logic rw);
    in_valid  = v;
    regin1    = r1;
    regin2    = r2;
    regin3    = r3;
    mem2regin = m2r;
    memwrin   = mw;
    regwrin   = rw;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] r1;
    logic [4:0]  r3;
    logic        rw;
    logic        ack;
    logic        e_valid;
    logic [31:0] e_data;
    logic [4:0]  e_dest;
    logic        e_regwr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int stall_cnt;
    int req_cnt;
    logic saw_err;

    vecs[0] = '{1'b1, 32'h0000_1234,  5'd5,  1'b1, 1'b0, 1'b1, 32'h0000_1234,  5'd5,  1'b1};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF,  5'd31, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF,  5'd31, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0000,  5'd0,  1'b1, 1'b0, 1'b1, 32'h0000_0000,  5'd0,  1'b1};
    vecs[3] = '{1'b0, 32'h0000_5555,  5'd7,  1'b0, 1'b0, 1'b0, 32'h0000_0000,  5'd0,  1'b1};
    vecs[4] = '{1'b1, 32'h8000_0003,  5'd12, 1'b1, 1'b1, 1'b1, 32'h8000_0003,  5'd12, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_0000,  5'd3,  1'b0, 1'b0, 1'b0, 32'h8000_0003,  5'd12, 1'b1};

    // Reset with live-looking inputs; all outputs must be cleared
    rst = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b1, 32'hCAFE_F00D, 32'h1111_2222, 5'd9, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    chk("rst_req",    {31'b0, dmem_req}, 32'h0);
    chk("rst_we",     {31'b0, dmem_we},  32'h0);
    chk("rst_addr",   dmem_addr,         32'h0);
    chk("rst_wdata",  dmem_wdata,        32'h0);
    chk("rst_valid",  {31'b0, wb_valid}, 32'h0);
    chk("rst_data",   wb_data,           32'h0);
    chk("rst_dest",   {27'b0, wb_dest},  32'h0);
    chk("rst_regwr",  {31'b0, wb_regwr}, 32'h0);
    chk("rst_err",    {31'b0, mem_err},  32'h0);
    rst = 1'b1;

    // ALU-op table: single-edge latency, no stall, stray acks ignored in IDLE
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].v, vecs[i].r1, 32'h0, vecs[i].r3, 1'b0, 1'b0, vecs[i].rw);
      dmem_ack = vecs[i].ack;
      #1;
      chk($sformatf("alu%0d_stall", i), {31'b0, stall}, 32'h0);
      tick();
      chk($sformatf("alu%0d_valid", i), {31'b0, wb_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("alu%0d_data", i),  wb_data,           vecs[i].e_data);
      chk($sformatf("alu%0d_dest", i),  {27'b0, wb_dest},  {27'b0, vecs[i].e_dest});
      chk($sformatf("alu%0d_regwr", i), {31'b0, wb_regwr}, {31'b0, vecs[i].e_regwr});
      chk($sformatf("alu%0d_req", i),   {31'b0, dmem_req}, 32'h0);
    end
    dmem_ack = 1'b0;

    // Load, ack three cycles after the request; upstream scribbles inputs while stalled
    stall_cnt = 0;
    drive(1'b1, 32'h0000_0104, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1);
    #1;
    if (stall) stall_cnt++;
    tick();
    chk("ld_req",   {31'b0, dmem_req}, 32'h1);
    chk("ld_we",    {31'b0, dmem_we},  32'h0);
    chk("ld_addr",  dmem_addr,         32'h0000_0104);
    chk("ld_wbv0",  {31'b0, wb_valid}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      regin1 = 32'h0BAD_0000 + c;
      regin3 = 5'd17;
      #1;
      if (stall) stall_cnt++;
      chk($sformatf("ld_hold_addr%0d", c), dmem_addr,         32'h0000_0104);
      chk($sformatf("ld_hold_req%0d", c),  {31'b0, dmem_req}, 32'h1);
      chk($sformatf("ld_err%0d", c),       {31'b0, mem_err},  32'h0);
      tick();
    end
    regin1 = 32'h0000_0104;
    regin3 = 5'd9;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_ack_stall", {31'b0, stall}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("ld_stall_cnt", stall_cnt,          32'd4);
    chk("ld_wb_valid",  {31'b0, wb_valid},  32'h1);
    chk("ld_wb_data",   wb_data,            32'hDEAD_BEEF);
    chk("ld_wb_dest",   {27'b0, wb_dest},   32'd9);
    chk("ld_wb_regwr",  {31'b0, wb_regwr},  32'h1);
    chk("ld_req_drop",  {31'b0, dmem_req},  32'h0);
    tick();
    chk("ld_wb_valid_drop", {31'b0, wb_valid}, 32'h0);

    // Store with ack in the first request cycle; regwrin must be masked
    drive(1'b1, 32'h0000_0203, 32'hA5A5_0000, 5'd4, 1'b0, 1'b1, 1'b1);
    #1;
    chk("st_stall0", {31'b0, stall}, 32'h1);
    tick();
    chk("st_addr",  dmem_addr,         32'h0000_0200);
    chk("st_we",    {31'b0, dmem_we},  32'h1);
    chk("st_wdata", dmem_wdata,        32'hA5A5_0000);
    chk("st_req",   {31'b0, dmem_req}, 32'h1);
    chk("st_wbv0",  {31'b0, wb_valid}, 32'h0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h7777_7777;
    #1;
    chk("st_ack_stall", {31'b0, stall}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("st_wb_valid", {31'b0, wb_valid}, 32'h1);
    chk("st_wb_regwr", {31'b0, wb_regwr}, 32'h0);
    chk("st_wb_data",  wb_data,           32'h0000_0203);
    chk("st_wb_dest",  {27'b0, wb_dest},  32'd4);
    chk("st_req_drop", {31'b0, dmem_req}, 32'h0);
    tick();

    // Reset during WAIT aborts the access; next ALU op completes normally
    drive(1'b1, 32'h0000_0300, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1);
    tick();
    chk("ra_req_open", {31'b0, dmem_req}, 32'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("ra_req",   {31'b0, dmem_req}, 32'h0);
    chk("ra_valid", {31'b0, wb_valid}, 32'h0);
    drive(1'b1, 32'h0000_0077, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1);
    #1;
    chk("ra_idle_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("ra_alu_valid", {31'b0, wb_valid}, 32'h1);
    chk("ra_alu_data",  wb_data,           32'h0000_0077);
    chk("ra_alu_dest",  {27'b0, wb_dest},  32'd3);

    // Back-to-back: load (ack after one wait cycle) followed by ALU op
    drive(1'b1, 32'h0000_0040, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
    tick();
    #1;
    chk("bb_wait_stall", {31'b0, stall}, 32'h1);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    #1;
    chk("bb_ack_stall", {31'b0, stall}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    drive(1'b1, 32'h0000_0ABC, 32'h0, 5'd6, 1'b0, 1'b0, 1'b1);
    chk("bb_ld_valid", {31'b0, wb_valid}, 32'h1);
    chk("bb_ld_data",  wb_data,           32'h1234_5678);
    chk("bb_ld_dest",  {27'b0, wb_dest},  32'd4);
    #1;
    chk("bb_alu_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("bb_alu_valid", {31'b0, wb_valid}, 32'h1);
    chk("bb_alu_data",  wb_data,           32'h0000_0ABC);
    chk("bb_alu_dest",  {27'b0, wb_dest},  32'd6);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();

`ifdef DMEM_TIMEOUT_EN
    // Load with no ack: request held TIMEOUT cycles, then error pulse and release
    req_cnt = 0;
    stall_cnt = 0;
    saw_err = 1'b0;
    drive(1'b1, 32'h0000_0500, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1);
    tick();
    for (int c = 0; c < 12; c++) begin
      if (!dmem_req) break;
      req_cnt++;
      #1;
      if (stall) stall_cnt++;
      if (mem_err) saw_err = 1'b1;
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("to_req_cycles",  req_cnt,              32'd4);
    chk("to_stall_cnt",   stall_cnt,            32'd3);
    chk("to_no_early_err",{31'b0, saw_err},     32'h0);
    chk("to_err",         {31'b0, mem_err},     32'h1);
    chk("to_valid",       {31'b0, wb_valid},    32'h1);
    chk("to_regwr",       {31'b0, wb_regwr},    32'h0);
    chk("to_req_drop",    {31'b0, dmem_req},    32'h0);
    #1;
    chk("to_release",     {31'b0, stall},       32'h0);
    tick();
    chk("to_err_pulse",   {31'b0, mem_err},     32'h0);
    chk("to_valid_drop",  {31'b0, wb_valid},    32'h0);
`else
    // Without the timeout feature the wait is unbounded
    req_cnt = 0;
    stall_cnt = 0;
    saw_err = 1'b0;
    drive(1'b1, 32'h0000_0500, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1);
    tick();
    for (int c = 0; c < 24; c++) begin
      if (dmem_req) req_cnt++;
      #1;
      if (stall) stall_cnt++;
      if (mem_err) saw_err = 1'b1;
      tick();
    end
    chk("nt_req_cycles", req_cnt,          32'd24);
    chk("nt_stall_cnt",  stall_cnt,        32'd24);
    chk("nt_no_err",     {31'b0, saw_err}, 32'h0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0F0F_0F0F;
    tick();
    dmem_ack = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("nt_wb_data",  wb_data,           32'h0F0F_0F0F);
    chk("nt_wb_regwr", {31'b0, wb_regwr}, 32'h1);
    chk("nt_wb_dest",  {27'b0, wb_dest},  32'd10);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
